bcd_to_bin_seq: RTL and testbench
=================================

Name: bcd_to_bin_seq

Overview:
Sequential BCD-to-binary converter using reverse double-dabble (shift right, subtract 3 from each BCD nibble >= 8). It is the inverse path of the binary-to-BCD display counter. It accepts 3-digit BCD values from the switch/keypad front end and returns a binary value through a start/done handshake. It is the input-side companion to the 7-segment display chain and uses one conversion iteration per clock to keep logic small on the Elbert board.

Parameters:
NDIG, 3, number of BCD digits on bcd_in
BIN_W, 10, binary result width; must be >= ceil(log2(10^NDIG)); 10 covers 999

Ports:
clk  input  1  system clock; all state on posedge clk
rst  input  1  asynchronous, active-low reset (asserted when 0)
start  input  1  request conversion of bcd_in; sampled only in IDLE
bcd_in  input  4*NDIG  packed BCD, digit NDIG-1 in MSBs; sampled on the edge that accepts start
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse; bin_out is valid and updated
err  output  1  one-cycle pulse; start rejected because a digit is > 9
bin_out  output  BIN_W  last converted result; holds between conversions

Behaviour:
- Reset (rst=0, async): state=IDLE; busy=0, done=0, err=0, bin_out=0; shift register and iteration counter = 0.
- States:
  - IDLE: waits for start.
  - SHIFT: performs BIN_W iterations.
- IDLE, start=1, all digits <= 9 at edge k:
  - load shift register {bcd_in, BIN_W'b0}, width 4*NDIG+BIN_W
  - counter=0; go to SHIFT; busy=1 from edge k.
- IDLE, start=1, any digit > 9 at edge k:
  - err=1 for the single cycle after edge k
  - stay IDLE; bin_out unchanged; busy stays 0.
- SHIFT, each edge:
  - logical shift right by 1; zero enters the MSB
  - then each BCD nibble of the shifted value >= 8 has 3 subtracted (4-bit, no borrow across nibbles)
  - counter increments.
- Completion:
  - shifts occur on edges k+1 .. k+BIN_W
  - on edge k+BIN_W: bin_out <= low BIN_W bits of the post-shift value (taken before correction), done=1, busy=0, state=IDLE.
  - Latency: done is high exactly BIN_W cycles after the accepting edge (10 cycles at default).
- done and err are mutually exclusive single-cycle pulses; both deassert on the following edge unless re-triggered.
- start while busy=1 is ignored; it is not queued and bcd_in is not resampled.
- start asserted in the done cycle (state already IDLE) is accepted; back-to-back conversions run with no idle gap.
- start held high continuously converts repeatedly, one conversion per BIN_W+1 edges.
- Counter width is clog2(BIN_W+1); it wraps to 0 on each load.
- Reset mid-SHIFT aborts immediately:
  - all outputs return to reset values, including bin_out=0
  - no done pulse is produced.
- bcd_in may change freely after the accepting edge; the result depends only on the sampled value.

Decomposition:
- Shared package bcd_pkg holds:
  - NDIG and BIN_W defaults
  - state encoding (IDLE, SHIFT)
  - the localparam SR_W = 4*NDIG+BIN_W.
- The display-side counter also takes its digit count from this package.
- One sub-module: bcd_nibble_sub3 (4-bit combinational: out = in>=8 ? in-3 : in). It is instantiated NDIG times via generate. It is the inverse of the add-3 cell used in binary-to-BCD.

Test Plan:
- Reset, then start with bcd_in=12'h999 -> done after exactly 10 cycles, bin_out=10'd999 (0x3E7), busy high for 10 cycles.
- Sweep bcd_in over 000..999, comparing against a reference model -> every result matches; 12'h000 -> bin_out=0; 12'h250 -> 250.
- Start with bcd_in=12'h9A3 -> err pulses 1 cycle, no busy, no done, bin_out holds its previous value.
- Start with 12'h123, then pulse start with 12'h456 at cycle 4 -> second request ignored; done gives 123; a later start gives 456.
- Start with 12'h777, drop rst to 0 at cycle 5, release -> outputs 0 and no done; a new start with 12'h042 -> bin_out=42.
- Hold start high with 12'h500, then 12'h501 -> consecutive done pulses 11 edges apart with values 500 and 501.

Source files
------------

// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_pkg
//  Description : Shared constants and state encoding for the BCD conversion
//                and display-counter blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    localparam int NDIG  = 3;
    localparam int BIN_W = 10;
    localparam int SR_W  = 4 * NDIG + BIN_W;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bcd_nibble_sub3.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_nibble_sub3
//  Description : Reverse double-dabble correction cell: subtract 3 from a
//                nibble that is 8 or more, otherwise pass it through.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_nibble_sub3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd8) ? (din - 4'd3) : din;

endmodule
`default_nettype wire

// File: rtl/bcd_to_bin_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_to_bin_seq
//  Description : Sequential BCD-to-binary converter, one reverse double-dabble
//                iteration per clock, start/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_bin_seq #(
    parameter int NDIG  = bcd_pkg::NDIG,
    parameter int BIN_W = bcd_pkg::BIN_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [4*NDIG-1:0]   bcd_in,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [BIN_W-1:0]    bin_out
);

    import bcd_pkg::*;

    localparam int               SHIFT_W = 4 * NDIG + BIN_W;
    localparam int               CNT_W   = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(BIN_W - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [SHIFT_W-1:0]   r_sr;
    logic [SHIFT_W-1:0]   w_sr_nxt;
    logic [SHIFT_W-1:0]   w_sr_shift;
    logic [SHIFT_W-1:0]   w_sr_corr;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 r_done;
    logic                 w_done_nxt;
    logic                 r_err;
    logic                 w_err_nxt;
    logic [BIN_W-1:0]     r_bin;
    logic [BIN_W-1:0]     w_bin_nxt;
    logic                 w_digits_ok;

    assign w_sr_shift = {1'b0, r_sr[SHIFT_W-1:1]};

    // The binary field below the BCD nibbles is never corrected.
    assign w_sr_corr[BIN_W-1:0] = w_sr_shift[BIN_W-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_nib
            bcd_nibble_sub3 u_sub3 (
                .din  (w_sr_shift[BIN_W + 4*gi +: 4]),
                .dout (w_sr_corr [BIN_W + 4*gi +: 4])
            );
        end
    endgenerate

    always_comb begin
        w_digits_ok = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) begin
                w_digits_ok = 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_bin_nxt   = r_bin;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_digits_ok) begin
                        w_sr_nxt    = {bcd_in, {BIN_W{1'b0}}};
                        w_cnt_nxt   = '0;
                        w_state_nxt = SHIFT;
                    end else begin
                        w_err_nxt   = 1'b1;
                    end
                end
            end
            SHIFT: begin
                w_sr_nxt  = w_sr_corr;
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == C_LAST) begin
                    w_bin_nxt   = w_sr_shift[BIN_W-1:0];
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_bin   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sr    <= w_sr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_bin   <= w_bin_nxt;
        end
    end

    assign busy    = (r_state == SHIFT);
    assign done    = r_done;
    assign err     = r_err;
    assign bin_out = r_bin;

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_bin_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_to_bin_seq
//  Description : Scoreboard bench for bcd_to_bin_seq with directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_to_bin_seq;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        start  = 1'b0;
    logic [11:0] bcd_in = 12'h000;
    logic        busy;
    logic        done;
    logic        err;
    logic [9:0]  bin_out;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int err_exp  = 0;
    int exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bcd_to_bin_seq dut (
        .clk     (clk),
        .rst     (rst_n),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .bin_out (bin_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every done, accounts for every err.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_done: got bin_out=%0d expected no done", bin_out);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    n_checks--;
                    check("done_value", 32'(bin_out), e);
                end
                check("done_err_excl", 32'(err), 0);
            end
            if (err) begin
                n_checks++;
                if (err_exp == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_err: got err=1 expected 0");
                end else begin
                    err_exp--;
                end
            end
        end
    end

    task automatic issue(input logic [11:0] bcd);
        start  = 1'b1;
        bcd_in = bcd;
        @(posedge clk);
        #1;
        start  = 1'b0;
        bcd_in = ~bcd;
    endtask

    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        do begin
            @(negedge clk);
            lat++;
            if (busy) busy_cnt++;
        end while (!done && lat < 60);
        if (!done) check("done_timeout", 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, bc, t1, t2;
        logic saw_done;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_bin", 32'(bin_out), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 999 with latency and busy length
        exp_q.push_back(999);
        issue(12'h999);
        wait_done(lat, bc);
        check("latency", lat - 1, 10);
        check("busy_cycles", bc, 10);
        check("bin_999", 32'(bin_out), 999);

        exp_q.push_back(0);
        issue(12'h000);
        wait_done(lat, bc);
        exp_q.push_back(250);
        issue(12'h250);
        wait_done(lat, bc);
        @(posedge clk);
        #1;

        // Invalid digit: single err pulse, no busy, result held
        err_exp++;
        issue(12'h9A3);
        @(negedge clk);
        check("err_pulse", 32'(err), 1);
        check("err_busy", 32'(busy), 0);
        check("err_hold_bin", 32'(bin_out), 250);
        @(negedge clk);
        check("err_single", 32'(err), 0);
        check("err_no_busy", 32'(busy), 0);
        check("err_no_done", 32'(done), 0);

        for (int p = 0; p < 3; p++) begin
            logic [11:0] bad;
            bad = 12'h000;
            bad[4*p +: 4] = 4'hA + 4'(p);
            err_exp++;
            @(posedge clk);
            #1;
            issue(bad);
            repeat (2) @(negedge clk);
        end

        // Start while busy is ignored
        @(posedge clk);
        #1;
        exp_q.push_back(123);
        issue(12'h123);
        repeat (3) @(posedge clk);
        #1;
        start  = 1'b1;
        bcd_in = 12'h456;
        @(posedge clk);
        #1;
        start  = 1'b0;
        wait_done(lat, bc);
        check("ignore_busy_bin", 32'(bin_out), 123);
        @(posedge clk);
        #1;
        exp_q.push_back(456);
        issue(12'h456);
        wait_done(lat, bc);

        // Reset mid-conversion
        @(posedge clk);
        #1;
        issue(12'h777);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_bin", 32'(bin_out), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", 32'(saw_done), 0);
        @(posedge clk);
        #1;
        exp_q.push_back(42);
        issue(12'h042);
        wait_done(lat, bc);
        check("after_abort_bin", 32'(bin_out), 42);

        // Start held high: back-to-back conversions
        @(posedge clk);
        #1;
        exp_q.push_back(500);
        exp_q.push_back(501);
        start  = 1'b1;
        bcd_in = 12'h500;
        @(posedge clk);
        #1;
        bcd_in = 12'h501;
        wait_done(lat, bc);
        t1 = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, bc);
        t2 = cyc;
        check("held_spacing", t2 - t1, 11);

        // Full sweep against the decimal model
        for (int d2 = 0; d2 < 10; d2++) begin
            for (int d1 = 0; d1 < 10; d1++) begin
                for (int d0 = 0; d0 < 10; d0++) begin
                    exp_q.push_back(d2 * 100 + d1 * 10 + d0);
                    issue({4'(d2), 4'(d1), 4'(d0)});
                    wait_done(lat, bc);
                end
            end
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        check("err_outstanding", err_exp, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
